// File: rtl/matvec_sequencer_pkg.sv
// Shared definitions for the matrix-vector sequencer: Q8.8 word format and FSM state encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package matvec_sequencer_pkg;

  // Operand/result word: signed Q8.8.
  localparam int WORD_W    = 16;
  localparam int FRAC_BITS = 8;

  // Sequencer state encoding (plain constants so legacy code can compare against them).
  typedef logic [3:0] state_t;
  localparam state_t IDLE     = 4'd0;
  localparam state_t LOAD_MAT = 4'd1;
  localparam state_t LOAD_VEC = 4'd2;
  localparam state_t START    = 4'd3;
  localparam state_t WAIT_LO  = 4'd4;
  localparam state_t WAIT_HI  = 4'd5;
  localparam state_t RD_ADDR  = 4'd6;
  localparam state_t RD_CAP   = 4'd7;
  localparam state_t RD_OUT   = 4'd8;

endpackage

// File: rtl/matvec_sequencer_load_addr_gen.sv
// Load address generator: row/column counter for the matrix phase, row-only counter for the vector phase.
// Latency: counters advance on the clock edge of each step; terminal flags are combinational.
// Backpressure: none; the caller only steps on an accepted host word.
// Ports: clr zeroes both counters (wins over step); step advances; vec_mode selects
//        index counting on row; row/col are the current address; mat_last/vec_last flag the final element.
module matvec_sequencer_load_addr_gen #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                step,
  input  logic                vec_mode,
  output logic [ROW_BITS-1:0] row,
  output logic [COL_BITS-1:0] col,
  output logic                mat_last,
  output logic                vec_last
);

  assign mat_last = (&row) & (&col);
  assign vec_last = &row;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row <= '0;
      col <= '0;
    end else if (clr) begin
      row <= '0;
      col <= '0;
    end else if (step) begin
      if (vec_mode) begin
        // Vector phase reuses the row counter as the element index.
        row <= row + 1'b1;
      end else begin
        col <= col + 1'b1;
        if (&col) row <= row + 1'b1;
      end
    end
  end

endmodule

// File: rtl/matvec_sequencer.sv
// Host-side sequencer: loads matrix then vector into operand memories, starts the engine, drains results.
// Latency: mm_start one cycle after the last vector word; drain yields one result per 3 cycles.
// Backpressure: in_valid stalls the load; out_ready low holds out_valid/out_data and the read index.
// Ports: in_* host operand stream; out_* result stream; busy/done status;
//        mat_*/vec_*/wdata operand memory write side; mm_* engine start/ready/result-read port.
module matvec_sequencer
  import matvec_sequencer_pkg::*;
#(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   out_data,
  output logic                busy,
  output logic                done,
  output logic                mat_write,
  output logic [ROW_BITS-1:0] mat_row,
  output logic [COL_BITS-1:0] mat_col,
  output logic                vec_write,
  output logic [ROW_BITS-1:0] vec_idx,
  output logic [WORD_W-1:0]   wdata,
  output logic                mm_start,
  input  logic                mm_ready,
  output logic [COL_BITS-1:0] mm_sel,
  input  logic [WORD_W-1:0]   mm_data
);

  state_t              state;
  state_t              state_nxt;
  logic [COL_BITS-1:0] k;
  logic [ROW_BITS-1:0] row;
  logic [COL_BITS-1:0] col;
  logic                mat_last;
  logic                vec_last;
  logic                in_hs;
  logic                in_vec;
  logic                cnt_clr;
  logic                out_hs;

  // in_ready is registered and is only ever high in IDLE/LOAD_MAT/LOAD_VEC,
  // so a handshake already implies a load state.
  assign in_hs  = in_valid & in_ready;
  assign in_vec = (state == LOAD_VEC);
  assign out_hs = (state == RD_OUT) & out_valid & out_ready;

  // Clear on the last element of either phase so the vector phase starts at index 0.
  assign cnt_clr = in_hs & (in_vec ? vec_last : mat_last);

  matvec_sequencer_load_addr_gen #(
    .ROW_BITS (ROW_BITS),
    .COL_BITS (COL_BITS)
  ) u_addr (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (cnt_clr),
    .step     (in_hs),
    .vec_mode (in_vec),
    .row      (row),
    .col      (col),
    .mat_last (mat_last),
    .vec_last (vec_last)
  );

  assign mat_write = in_hs & ~in_vec;
  assign vec_write = in_hs & in_vec;
  assign mat_row   = row;
  assign mat_col   = col;
  assign vec_idx   = row;
  assign wdata     = in_data;
  assign busy      = (state != IDLE);
  assign mm_start  = (state == START);
  // k is held from RD_ADDR through RD_OUT, so the engine read select stays stable for the whole read.
  assign mm_sel    = k;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (in_hs) state_nxt = LOAD_MAT;
      LOAD_MAT: if (in_hs && mat_last) state_nxt = LOAD_VEC;
      LOAD_VEC: if (in_hs && vec_last) state_nxt = START;
      START:    state_nxt = WAIT_LO;
      // Wait for the engine to drop ready first so a stale idle level is never taken as completion.
      WAIT_LO:  if (!mm_ready) state_nxt = WAIT_HI;
      WAIT_HI:  if (mm_ready) state_nxt = RD_ADDR;
      RD_ADDR:  state_nxt = RD_CAP;
      RD_CAP:   state_nxt = RD_OUT;
      RD_OUT:   if (out_hs) state_nxt = (&k) ? IDLE : RD_ADDR;
      default:  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b0;
      k         <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      done      <= 1'b0;
    end else begin
      state    <= state_nxt;
      in_ready <= (state_nxt == IDLE) || (state_nxt == LOAD_MAT) || (state_nxt == LOAD_VEC);
      done     <= 1'b0;
      if (state == WAIT_HI && mm_ready) k <= '0;
      // Engine read data is valid the cycle after mm_sel is presented (RD_ADDR -> RD_CAP).
      if (state == RD_CAP) begin
        out_data  <= mm_data;
        out_valid <= 1'b1;
      end
      if (out_hs) begin
        out_valid <= 1'b0;
        if (&k) begin
          done <= 1'b1;
          k    <= '0;
        end else begin
          k <= k + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_matvec_sequencer.sv
// Testbench for matvec_sequencer: directed loads, engine model, scoreboarded write and result streams.
// Latency: n/a.
// Backpressure: exercises in_valid gaps and an out_ready stall at result 7.
module tb_matvec_sequencer;
  import matvec_sequencer_pkg::*;

  localparam logic [15:0] ONE = 16'(1 << FRAC_BITS);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_data = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        busy;
  logic        done;
  logic        mat_write;
  logic [1:0]  mat_row;
  logic [3:0]  mat_col;
  logic        vec_write;
  logic [1:0]  vec_idx;
  logic [15:0] wdata;
  logic        mm_start;
  logic        mm_ready = 1'b1;
  logic [3:0]  mm_sel;
  logic [15:0] mm_data = '0;

  matvec_sequencer dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy), .done(done),
    .mat_write(mat_write), .mat_row(mat_row), .mat_col(mat_col),
    .vec_write(vec_write), .vec_idx(vec_idx), .wdata(wdata),
    .mm_start(mm_start), .mm_ready(mm_ready), .mm_sel(mm_sel), .mm_data(mm_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [31:0] wr_q[$];
  logic [15:0] out_q[$];
  int wr_seen = 0;
  int nout = 0;
  int last_out_cyc = -1;
  int last_hs_cyc = 0;
  int start_cnt = 0;
  int start_cyc = -1;
  int done_cnt = 0;
  int stall_cnt = 0;
  bit chk_spacing = 1'b0;
  bit stall_en = 1'b0;
  bit eng_low = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Write scoreboard: every memory write must match the next expected {type,row,col,data}.
  always @(negedge clk) begin
    if (mat_write || vec_write) begin
      logic [31:0] act;
      wr_seen++;
      chk("wr_needs_valid", 32'(in_valid), 1);
      chk("wr_not_both", 32'(mat_write & vec_write), 0);
      act = mat_write ? {8'd0, 4'(mat_row), mat_col, wdata} : {8'd1, 4'(vec_idx), 4'd0, wdata};
      chk("wr_expected", 32'(wr_q.size() != 0), 1);
      if (wr_q.size() != 0) chk("wr_addr_data", act, wr_q.pop_front());
    end
  end

  // Result scoreboard, drain spacing, engine-wait guard and stall stability.
  always @(negedge clk) begin
    if (out_valid && eng_low) chk("no_read_before_mm_ready", 32'(eng_low), 0);
    if (stall_en && out_valid && !out_ready) begin
      stall_cnt++;
      chk("stall_out_data", 32'(out_data), 32'h0070);
    end
    if (out_valid && out_ready) begin
      if (chk_spacing && last_out_cyc >= 0) chk("out_spacing", 32'(cyc - last_out_cyc), 3);
      chk("out_expected", 32'(out_q.size() != 0), 1);
      if (out_q.size() != 0) chk("out_data", 32'(out_data), 32'(out_q.pop_front()));
      last_out_cyc = cyc;
      nout++;
    end
    if (done) begin
      done_cnt++;
      chk("done_after_last", 32'(cyc - last_out_cyc), 1);
      chk("done_nout", 32'(nout), 16);
    end
  end

  // out_ready driver: held low for 10 valid cycles at result index 7 when the stall is enabled.
  always @(posedge clk) begin
    #1;
    out_ready = !(stall_en && nout == 7 && stall_cnt < 10);
  end

  // Engine model: ready drops one cycle after the start pulse, returns 70 cycles later.
  initial begin
    forever begin
      @(negedge clk);
      if (mm_start) begin
        start_cnt++;
        start_cyc = cyc;
        @(posedge clk);
        @(posedge clk);
        #1 mm_ready = 1'b0;
        eng_low = 1'b1;
        repeat (70) @(posedge clk);
        #1 mm_ready = 1'b1;
        eng_low = 1'b0;
      end
    end
  end

  // Engine result read: one-cycle latency from mm_sel, result[k] = k*0x0010.
  always @(posedge clk) begin
    #1;
    mm_data = 16'(mm_sel) << 4;
  end

  task automatic send(input logic [15:0] d, input int gap);
    bit hs;
    hs = 1'b0;
    if (gap > 0) begin
      in_valid = 1'b0;
      repeat (gap) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = d;
    for (int t = 0; t < 50 && !hs; t++) begin
      @(negedge clk);
      hs = in_ready;
      @(posedge clk);
      #1;
    end
    chk("send_accept", 32'(hs), 1);
    last_hs_cyc = cyc;
  endtask

  task automatic load_all(input bit gaps, input bit varied);
    logic [15:0] d;
    for (int i = 0; i < 64; i++) begin
      d = varied ? 16'(i * 37 + 5) : ONE;
      wr_q.push_back({8'd0, 4'(i / 16), 4'(i % 16), d});
      send(d, gaps ? int'($urandom_range(0, 2)) : 0);
    end
    for (int j = 0; j < 4; j++) begin
      d = varied ? 16'(16'hA000 + j) : ONE;
      wr_q.push_back({8'd1, 4'(j), 4'd0, d});
      send(d, gaps ? int'($urandom_range(0, 2)) : 0);
    end
    in_valid = 1'b0;
  endtask

  task automatic run_op(input bit gaps, input bit varied, input int run_no);
    wr_seen = 0;
    nout = 0;
    last_out_cyc = -1;
    for (int k = 0; k < 16; k++) out_q.push_back(16'(k * 16));
    load_all(gaps, varied);
    chk("load_write_count", 32'(wr_seen), 68);
    // mm_start is high in the cycle right after the last vector handshake edge.
    for (int t = 0; t < 5 && start_cnt < run_no; t++) begin @(posedge clk); #1; end
    chk("start_follows_last_vec", 32'(start_cyc), 32'(last_hs_cyc));
    // Host words during the engine run must be refused and never written.
    in_valid = 1'b1;
    in_data  = 16'hDEAD;
    repeat (10) begin @(posedge clk); #1; end
    chk("in_ready_low_while_busy", 32'(in_ready), 0);
    chk("busy_while_running", 32'(busy), 1);
    in_valid = 1'b0;
    for (int t = 0; t < 600 && done_cnt < run_no; t++) begin @(posedge clk); #1; end
    chk("done_count", 32'(done_cnt), 32'(run_no));
    chk("start_count", 32'(start_cnt), 32'(run_no));
    chk("results_drained", 32'(nout), 16);
    chk("out_q_empty", 32'(out_q.size()), 0);
    chk("wr_q_empty", 32'(wr_q.size()), 0);
    chk("writes_after_load", 32'(wr_seen), 68);
    repeat (3) begin @(posedge clk); #1; end
    chk("idle_busy", 32'(busy), 0);
    chk("idle_in_ready", 32'(in_ready), 1);
    chk("done_single_pulse", 32'(done_cnt), 32'(run_no));
  endtask

  initial begin
    // Reset state.
    #2;
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_strobes", {29'd0, mat_write, vec_write, mm_start}, 0);
    chk("rst_addrs", {18'd0, out_data, mm_sel, mat_row, mat_col, vec_idx} & 32'hFFFF_FFFF, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);

    // Reset in the middle of a matrix load.
    for (int i = 0; i < 5; i++) begin
      wr_q.push_back({8'd0, 4'd0, 4'(i), 16'(16'h1000 + i)});
      send(16'(16'h1000 + i), 0);
    end
    in_valid = 1'b0;
    chk("midload_busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_counters", {24'd0, 2'(mat_row), mat_col, vec_idx}, 0);
    repeat (5) begin @(posedge clk); #1; end
    chk("midrst_write_count", 32'(wr_seen), 5);
    chk("midrst_wr_q_empty", 32'(wr_q.size()), 0);

    // Gap-free load with 1.0 operands, free-flowing drain.
    chk_spacing = 1'b1;
    run_op(1'b0, 1'b0, 1);

    // Gapped load with distinct data, out_ready stall at result 7.
    chk_spacing = 1'b0;
    stall_en = 1'b1;
    stall_cnt = 0;
    run_op(1'b1, 1'b1, 2);
    chk("stall_cycles", 32'(stall_cnt), 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL global_timeout actual=%0t required=<400000", $time);
    $fatal(1, "timeout");
  end

endmodule
